// File: rtl/axi_rom_read_arbiter.sv
// Round-robin arbiter sharing a one-cycle-latency ROM between two AXI-Lite read ports.
// Define AXI_ROM_ARB_RANGE_CHECK_EN to answer out-of-window reads with SLVERR instead of wrapping.
module axi_rom_read_arbiter #(
  parameter logic [63:0] MEM_BASE = 64'h1000,
  parameter int          MEM_SIZE = 12,
  parameter int          DW       = 64,
  localparam int         AW       = MEM_SIZE,
  localparam int         LSB      = $clog2(DW/8),
  localparam int         MAW      = 1 + AW - LSB
) (
  input  logic           clk_i,
  input  logic           arst_i,
  input  logic           ar0_valid_i,
  output logic           ar0_ready_o,
  input  logic [63:0]    ar0_addr_i,
  input  logic [2:0]     ar0_prot_i,
  output logic           r0_valid_o,
  input  logic           r0_ready_i,
  output logic [DW-1:0]  r0_data_o,
  output logic [1:0]     r0_resp_o,
  input  logic           ar1_valid_i,
  output logic           ar1_ready_o,
  input  logic [63:0]    ar1_addr_i,
  input  logic [2:0]     ar1_prot_i,
  output logic           r1_valid_o,
  input  logic           r1_ready_i,
  output logic [DW-1:0]  r1_data_o,
  output logic [1:0]     r1_resp_o,
  output logic           mem_en_o,
  output logic [MAW-1:0] mem_addr_o,
  input  logic [DW-1:0]  mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    resp_q, resp_d;

  logic          any_req;
  logic          gnt;
  logic [63:0]   req_addr;
  logic [2:0]    req_prot;
  logic [64:0]   diff;
  logic          in_range;
  logic          unused_bits;

  // On a tie the port that did not win last time is chosen; a lone requester always wins.
  assign any_req  = ar0_valid_i | ar1_valid_i;
  assign gnt      = (ar0_valid_i & ar1_valid_i) ? ~last_q : ar1_valid_i;
  assign req_addr = gnt ? ar1_addr_i : ar0_addr_i;
  assign req_prot = gnt ? ar1_prot_i : ar0_prot_i;

  // 65-bit difference: bit 64 flags addr < base, so the window test cannot overflow.
  assign diff = {1'b0, req_addr} - {1'b0, MEM_BASE};

`ifdef AXI_ROM_ARB_RANGE_CHECK_EN
  assign in_range    = ~diff[64] && (diff[63:AW] == '0);
  assign unused_bits = ^{ar0_prot_i[2], ar0_prot_i[0], ar1_prot_i[2], ar1_prot_i[0], diff[LSB-1:0]};
`else
  assign in_range    = 1'b1;
  assign unused_bits = ^{ar0_prot_i[2], ar0_prot_i[0], ar1_prot_i[2], ar1_prot_i[0], diff[LSB-1:0],
                         diff[64:AW]};
`endif

  assign mem_addr_o = {req_prot[1], diff[AW-1:LSB]};

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d  = gnt;
          last_d = gnt;
          if (in_range) begin
            state_d = DATA;
          end else begin
            rdata_d = '0;
            resp_d  = 2'b10;
            state_d = RESP;
          end
        end
      end
      DATA: begin
        rdata_d = mem_rdata_i;
        resp_d  = 2'b00;
        state_d = RESP;
      end
      RESP: begin
        if (sel_q ? r1_ready_i : r0_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ar0_ready_o = (state_q == IDLE) && any_req && !gnt;
    ar1_ready_o = (state_q == IDLE) && any_req && gnt;
    mem_en_o    = (state_q == IDLE) && any_req && in_range;
    r0_valid_o  = (state_q == RESP) && !sel_q;
    r1_valid_o  = (state_q == RESP) && sel_q;
    r0_data_o   = rdata_q;
    r1_data_o   = rdata_q;
    r0_resp_o   = resp_q;
    r1_resp_o   = resp_q;
  end

endmodule

// File: tb/tb_axi_rom_read_arbiter.sv
// Directed bench for axi_rom_read_arbiter with a grant-time scoreboard and a ROM model.
// Range tests follow AXI_ROM_ARB_RANGE_CHECK_EN exactly as the design does.
module tb_axi_rom_read_arbiter;

  localparam logic [63:0] BASE = 64'h1000;

  typedef struct {
    int          port;
    logic [63:0] data;
    logic [1:0]  resp;
    int          lat;
    int          gcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst;
  logic        ar0_valid, ar0_ready, r0_valid, r0_ready;
  logic        ar1_valid, ar1_ready, r1_valid, r1_ready;
  logic [63:0] ar0_addr, ar1_addr, r0_data, r1_data, mem_rdata;
  logic [2:0]  ar0_prot, ar1_prot;
  logic [1:0]  r0_resp, r1_resp;
  logic        mem_en;
  logic [9:0]  mem_addr;

  exp_t sb[$];
  int   glog[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nresp = 0;
  bit   front_seen = 0;
  bit   hold0 = 0, hold1 = 0;
  int   last_hs_cyc = 0, last_grant_cyc = 0;
  int   mark;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_rom_read_arbiter dut (
    .clk_i(clk), .arst_i(arst),
    .ar0_valid_i(ar0_valid), .ar0_ready_o(ar0_ready), .ar0_addr_i(ar0_addr), .ar0_prot_i(ar0_prot),
    .r0_valid_o(r0_valid), .r0_ready_i(r0_ready), .r0_data_o(r0_data), .r0_resp_o(r0_resp),
    .ar1_valid_i(ar1_valid), .ar1_ready_o(ar1_ready), .ar1_addr_i(ar1_addr), .ar1_prot_i(ar1_prot),
    .r1_valid_o(r1_valid), .r1_ready_i(r1_ready), .r1_data_o(r1_data), .r1_resp_o(r1_resp),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [63:0] mem_f(logic [9:0] a);
    return {22'h2A5A5A, a, 22'h15C3C3, a};
  endfunction

  // ROM model: data valid only in the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_f(mem_addr);
    else        mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  function automatic bit tb_in_range(logic [63:0] a);
`ifdef AXI_ROM_ARB_RANGE_CHECK_EN
    return (a >= BASE) && ((a - BASE) < 64'h1000);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [9:0] tb_word(logic [63:0] a, logic [2:0] pr);
    logic [63:0] off;
    off = (a - BASE) % 64'h1000;
    return {pr[1], 9'(off / 8)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit g0, g1;
    int p;
    logic [63:0] a;
    logic [2:0] pr;
    exp_t e;
    g0 = 0; g1 = 0;
    @(negedge clk);
    if (ar0_ready || ar1_ready) begin
      chk("ar_ready_excl", {63'd0, ar0_ready & ar1_ready}, 64'd0);
      p  = ar1_ready ? 1 : 0;
      a  = p ? ar1_addr : ar0_addr;
      pr = p ? ar1_prot : ar0_prot;
      chk("grant_has_valid", {63'd0, p ? ar1_valid : ar0_valid}, 64'd1);
      chk("mem_en", {63'd0, mem_en}, {63'd0, tb_in_range(a)});
      if (tb_in_range(a)) chk("mem_addr", {54'd0, mem_addr}, {54'd0, tb_word(a, pr)});
      e.port = p;
      e.resp = tb_in_range(a) ? 2'b00 : 2'b10;
      e.data = tb_in_range(a) ? mem_f(tb_word(a, pr)) : 64'd0;
      e.lat  = tb_in_range(a) ? 2 : 1;
      e.gcyc = cyc;
      sb.push_back(e);
      glog.push_back(p);
      last_grant_cyc = cyc;
      if (p == 0) g0 = 1; else g1 = 1;
      $display("grant port=%0d addr=%0h cyc=%0d", p, a, cyc);
    end else if (mem_en) begin
      chk("mem_en_without_grant", {63'd0, mem_en}, 64'd0);
    end
    if (r0_valid || r1_valid) begin
      chk("busy_ready_memen", {61'd0, ar0_ready, ar1_ready, mem_en}, 64'd0);
      chk("r_valid_excl", {63'd0, r0_valid & r1_valid}, 64'd0);
      p = r1_valid ? 1 : 0;
      if (sb.size() == 0) begin
        chk("resp_expected", 64'(sb.size()), 64'd1);
      end else begin
        chk("resp_port", 64'(p), 64'(sb[0].port));
        chk("r_data", p ? r1_data : r0_data, sb[0].data);
        chk("r_resp", {62'd0, p ? r1_resp : r0_resp}, {62'd0, sb[0].resp});
        if (!front_seen) begin
          chk("latency", 64'(cyc - sb[0].gcyc), 64'(sb[0].lat));
          front_seen = 1;
        end
        if (p ? r1_ready : r0_ready) begin
          $display("resp port=%0d data=%0h resp=%0d cyc=%0d", p, p ? r1_data : r0_data,
                   p ? r1_resp : r0_resp, cyc);
          void'(sb.pop_front());
          front_seen  = 0;
          nresp++;
          last_hs_cyc = cyc;
        end
      end
    end
    @(posedge clk);
    #1;
    if (g0) begin if (hold0) ar0_addr += 8; else ar0_valid = 0; end
    if (g1) begin if (hold1) ar1_addr += 8; else ar1_valid = 0; end
  endtask

  task automatic run_until(int target, int budget);
    int n = 0;
    while (nresp < target && n < budget) begin
      tick();
      n++;
    end
    chk("responses_within_budget", 64'(nresp), 64'(target));
  endtask

  task automatic rd(int p, logic [63:0] a, logic [2:0] pr);
    if (p == 0) begin ar0_addr = a; ar0_prot = pr; ar0_valid = 1; end
    else        begin ar1_addr = a; ar1_prot = pr; ar1_valid = 1; end
    run_until(nresp + 1, 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1; ar0_valid = 0; ar1_valid = 0; r0_ready = 1; r1_ready = 1;
    ar0_addr = 0; ar1_addr = 0; ar0_prot = 0; ar1_prot = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r_valid", {62'd0, r0_valid, r1_valid}, 64'd0);
    chk("rst_ar_ready_memen", {61'd0, ar0_ready, ar1_ready, mem_en}, 64'd0);
    chk("rst_data", r0_data, 64'd0);
    chk("rst_resp", {62'd0, r0_resp}, 64'd0);
    @(posedge clk); #1;
    arst = 0;

    // Single reads; the last one is on port 1 so contention starts with port 0.
    rd(0, BASE + 64'h8, 3'b000);
    rd(0, BASE + 64'hFF8, 3'b000);
    rd(1, BASE + 64'h10, 3'b010);

    // Contention: both ports stay valid for six transactions.
    mark = glog.size();
    hold0 = 1; hold1 = 1;
    ar0_addr = BASE + 64'h100; ar1_addr = BASE + 64'h200; ar0_prot = 0; ar1_prot = 0;
    ar0_valid = 1; ar1_valid = 1;
    run_until(nresp + 6, 40);
    ar0_valid = 0; ar1_valid = 0; hold0 = 0; hold1 = 0;
    chk("contention_grants", 64'(glog.size() - mark), 64'd6);
    for (int i = 0; i < 6 && mark + i < glog.size(); i++)
      chk("grant_order", 64'(glog[mark + i]), 64'(i % 2));

    // Backpressure on port 1 with port 0 waiting.
    r1_ready = 0;
    ar1_addr = BASE + 64'h30; ar1_valid = 1;
    for (int i = 0; i < 10 && !r1_valid; i++) tick();
    chk("bp_r1_valid", {63'd0, r1_valid}, 64'd1);
    ar0_addr = BASE + 64'h40; ar0_valid = 1;
    repeat (5) tick();
    r1_ready = 1;
    tick();
    tick();
    chk("bp_idle_after_hs", 64'(last_grant_cyc - last_hs_cyc), 64'd1);
    chk("bp_next_grant_port", 64'(glog[glog.size() - 1]), 64'd0);
    run_until(nresp + 1, 20);

`ifdef AXI_ROM_ARB_RANGE_CHECK_EN
    rd(0, BASE - 64'h8, 3'b000);
    rd(1, BASE + 64'h1000, 3'b000);
    rd(0, 64'hFFFF_FFFF_FFFF_FFF8, 3'b000);
    rd(1, BASE + 64'hFF8, 3'b000);
`else
    rd(0, BASE + 64'h1008, 3'b000);
    rd(1, BASE - 64'h8, 3'b000);
`endif

    // Reset while port 0's response is pending.
    r0_ready = 0;
    ar0_addr = BASE + 64'h18; ar0_valid = 1;
    for (int i = 0; i < 10 && !r0_valid; i++) tick();
    chk("rst_mid_r0_valid_before", {63'd0, r0_valid}, 64'd1);
    arst = 1;
    #1;
    chk("rst_mid_r0_valid_async", {63'd0, r0_valid}, 64'd0);
    sb.delete();
    front_seen = 0;
    @(posedge clk); #1;
    arst = 0;
    r0_ready = 1;
    mark = glog.size();
    ar0_addr = BASE + 64'h20; ar1_addr = BASE + 64'h28;
    ar0_valid = 1; ar1_valid = 1;
    run_until(nresp + 2, 20);
    chk("post_rst_first_grant", 64'(glog.size() > mark ? glog[mark] : -1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
